// File: rtl/port_gpio_irq_if.sv
// Register-access bus of the GPIO/IRQ port block: core-side write data, address,
// strobe, plus read data and the interrupt request coming back.
interface port_gpio_irq_if #(
    parameter int DATA_W   = 8,
    parameter int PORT_CNT = 3
);
    localparam int PSEL_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

    logic [DATA_W-1:0] dane;
    logic [PSEL_W-1:0] port_sel;
    logic [3:0]        reg_sel;
    logic              wr;
    logic [DATA_W-1:0] out;
    logic              irq;

    modport master (output dane, port_sel, reg_sel, wr, input  out, irq);
    modport slave  (input  dane, port_sel, reg_sel, wr, output out, irq);
endinterface

// File: rtl/port_gpio_irq.sv
// Parametrised GPIO ports with pad synchronisers, atomic set/clear/toggle writes
// and per-bit rising/falling edge interrupt flags folded into one request.
module port_gpio_irq_lane #(
    parameter int               DATA_W      = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RST_DDR    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_i,
    input  logic              wr_i,
    input  logic [3:0]        reg_sel_i,
    input  logic [DATA_W-1:0] dane_i,
    input  logic [DATA_W-1:0] pad_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] ddr_o,
    output logic [DATA_W-1:0] port_o,
    output logic              irq_o
);
    localparam logic [3:0] REG_DDR  = 4'd0;
    localparam logic [3:0] REG_PORT = 4'd1;
    localparam logic [3:0] REG_PIN  = 4'd2;
    localparam logic [3:0] REG_PSET = 4'd3;
    localparam logic [3:0] REG_PCLR = 4'd4;
    localparam logic [3:0] REG_PTGL = 4'd5;
    localparam logic [3:0] REG_IRE  = 4'd6;
    localparam logic [3:0] REG_IFE  = 4'd7;
    localparam logic [3:0] REG_IFR  = 4'd8;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [DATA_W-1:0] ddr_q, ddr_d, port_q, port_d, ire_q, ire_d, ife_q, ife_d;
    logic [DATA_W-1:0] ifr_q, ifr_d, prev_q, pin, set, clr;
    logic              wr_hit;

    assign wr_hit = wr_i & sel_i;
    assign pin    = sync_q[SYNC_STAGES-1];
    // Enables are the current-cycle values; a same-cycle IRE/IFE write acts next cycle.
    assign set    = (pin & ~prev_q & ire_q) | (~pin & prev_q & ife_q);

    always_comb begin
        ddr_d  = ddr_q;
        port_d = port_q;
        ire_d  = ire_q;
        ife_d  = ife_q;
        clr    = '0;
        if (wr_hit) begin
            case (reg_sel_i)
                REG_DDR:  ddr_d  = dane_i;
                REG_PORT: port_d = dane_i;
                REG_PSET: port_d = port_q | dane_i;
                REG_PCLR: port_d = port_q & ~dane_i;
                REG_PTGL: port_d = port_q ^ dane_i;
                REG_IRE:  ire_d  = dane_i;
                REG_IFE:  ife_d  = dane_i;
                REG_IFR:  clr    = dane_i;
                default:  ;
            endcase
        end
        // OR-ing set after the clear makes a colliding edge win over W1C.
        ifr_d = (ifr_q & ~clr) | set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
            ddr_q  <= RST_DDR;
            port_q <= '0;
            ire_q  <= '0;
            ife_q  <= '0;
            ifr_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= pin;
            ddr_q  <= ddr_d;
            port_q <= port_d;
            ire_q  <= ire_d;
            ife_q  <= ife_d;
            ifr_q  <= ifr_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_sel_i)
            REG_DDR:  rdata_o = ddr_q;
            REG_PORT: rdata_o = port_q;
            REG_PIN:  rdata_o = pin;
            REG_IRE:  rdata_o = ire_q;
            REG_IFE:  rdata_o = ife_q;
            REG_IFR:  rdata_o = ifr_q;
            default:  rdata_o = '0;
        endcase
    end

    assign ddr_o  = ddr_q;
    assign port_o = port_q;
    assign irq_o  = |ifr_q;
endmodule

module port_gpio_irq #(
    parameter int                         DATA_W      = 8,
    parameter int                         PORT_CNT    = 3,
    parameter int                         SYNC_STAGES = 2,
    parameter logic [PORT_CNT*DATA_W-1:0] RESET_DDR   = {8'hFF, 8'h00, 8'h00}
) (
    input  logic                         clk,
    input  logic                         rst,
    port_gpio_irq_if.slave               bus,
    inout  wire  [PORT_CNT*DATA_W-1:0]   pins
);
    localparam int PSEL_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

    logic [PORT_CNT-1:0][DATA_W-1:0] rdata, ddr, port;
    logic [PORT_CNT-1:0]             lane_irq;

    for (genvar p = 0; p < PORT_CNT; p++) begin : g_lane
        port_gpio_irq_lane #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RST_DDR     (RESET_DDR[p*DATA_W +: DATA_W])
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .sel_i     (bus.port_sel == PSEL_W'(p)),
            .wr_i      (bus.wr),
            .reg_sel_i (bus.reg_sel),
            .dane_i    (bus.dane),
            .pad_i     (pins[p*DATA_W +: DATA_W]),
            .rdata_o   (rdata[p]),
            .ddr_o     (ddr[p]),
            .port_o    (port[p]),
            .irq_o     (lane_irq[p])
        );
        for (genvar b = 0; b < DATA_W; b++) begin : g_pad
            assign pins[p*DATA_W + b] = ddr[p][b] ? port[p][b] : 1'bz;
        end
    end

    // Unmatched port_sel (out of range) falls through to zero.
    always_comb begin
        bus.out = '0;
        for (int p = 0; p < PORT_CNT; p++)
            if (bus.port_sel == PSEL_W'(p)) bus.out = rdata[p];
    end

    assign bus.irq = |lane_irq;
endmodule

// File: tb/tb_port_gpio_irq.sv
// Bench for port_gpio_irq: directed scenarios plus randomised traffic, all checked
// against a pad-history/register-array model of the port block.
module tb_port_gpio_irq;
  localparam int W = 8, P = 3, S = 2, N = P*W;
  localparam logic [N-1:0] RDDR = 24'hFF0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [N-1:0] pins;
  logic [N-1:0] tb_val = '0;
  logic [N-1:0] tb_en;
  int checks = 0, errors = 0;

  logic [N-1:0] m_ddr, m_port, m_ire, m_ife, m_ifr;
  logic [N-1:0] hist[$];   // sampled pad values, newest first

  port_gpio_irq_if #(.DATA_W(W), .PORT_CNT(P)) bus();

  port_gpio_irq #(.DATA_W(W), .PORT_CNT(P), .SYNC_STAGES(S), .RESET_DDR(RDDR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pins(pins));

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  function automatic logic [N-1:0] m_pad();
    return (m_ddr & m_port) | (~m_ddr & tb_val);
  endfunction

  function automatic void m_reset();
    m_ddr = RDDR; m_port = '0; m_ire = '0; m_ife = '0; m_ifr = '0;
    hist.delete();
    repeat (S+1) hist.push_back('0);
  endfunction

  function automatic void m_step(logic w, int ps, int rs, logic [W-1:0] d, logic [N-1:0] pad);
    logic [N-1:0] pin, prev, set, clr;
    int b;
    pin  = hist[S-1];
    prev = hist[S];
    set  = (pin & ~prev & m_ire) | (~pin & prev & m_ife);
    clr  = '0;
    if (w && ps < P) begin
      b = ps*W;
      case (rs)
        0: m_ddr[b +: W]  = d;
        1: m_port[b +: W] = d;
        3: m_port[b +: W] = m_port[b +: W] | d;
        4: m_port[b +: W] = m_port[b +: W] & ~d;
        5: m_port[b +: W] = m_port[b +: W] ^ d;
        6: m_ire[b +: W]  = d;
        7: m_ife[b +: W]  = d;
        8: clr[b +: W]    = d;
        default: ;
      endcase
    end
    m_ifr = (m_ifr & ~clr) | set;
    hist.push_front(pad);
    void'(hist.pop_back());
  endfunction

  function automatic logic [W-1:0] m_read(int ps, int rs);
    logic [N-1:0] pin;
    int b;
    if (ps >= P) return '0;
    b = ps*W;
    pin = hist[S-1];
    case (rs)
      0: return m_ddr[b +: W];
      1: return m_port[b +: W];
      2: return pin[b +: W];
      6: return m_ire[b +: W];
      7: return m_ife[b +: W];
      8: return m_ifr[b +: W];
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
      tb_en <= ~RDDR;
    end else begin
      m_step(bus.wr, int'(bus.port_sel), int'(bus.reg_sel), bus.dane, m_pad());
      tb_en <= ~m_ddr;
    end
  end

  task automatic cycle(input logic w, input int ps, input int rs, input logic [W-1:0] d);
    @(negedge clk);
    bus.wr = w; bus.port_sel = 2'(ps); bus.reg_sel = 4'(rs); bus.dane = d;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 8'h00);
  endtask

  task automatic rd(input int ps, input int rs, output logic [W-1:0] v);
    bus.wr = 1'b0; bus.port_sel = 2'(ps); bus.reg_sel = 4'(rs);
    #1;
    v = bus.out;
  endtask

  task automatic test_reset();
    logic [W-1:0] v, e;
    int regs[4] = '{1, 6, 7, 8};
    bus.wr = 1'b0; bus.port_sel = '0; bus.reg_sel = '0; bus.dane = '0;
    tb_val = 24'h003C5A;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    checks++;
    if (pins[23:16] !== 8'h00) begin errors++; $display("FAIL reset_pins2: got %h expected 00", pins[23:16]); end
    checks++;
    if (pins[15:0] !== 16'h3C5A) begin errors++; $display("FAIL reset_pins01: got %h expected 3c5a", pins[15:0]); end
    for (int p = 0; p < P; p++) begin
      rd(p, 0, v);
      e = (p == 2) ? 8'hFF : 8'h00;
      checks++;
      if (v !== e) begin errors++; $display("FAIL reset_ddr%0d: got %h expected %h", p, v, e); end
      foreach (regs[k]) begin
        rd(p, regs[k], v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d_p%0d: got %h expected 00", regs[k], p, v); end
      end
    end
  endtask

  task automatic test_atomic();
    logic [W-1:0] v;
    int ops[4] = '{1, 3, 4, 5};
    logic [W-1:0] dat[4] = '{8'hA5, 8'h0A, 8'h81, 8'hFF};
    logic [W-1:0] exp[4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2, ops[i], dat[i]);
      checks++;
      if (pins[23:16] !== exp[i]) begin errors++; $display("FAIL atomic_pins_op%0d: got %h expected %h", ops[i], pins[23:16], exp[i]); end
      rd(2, 1, v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL atomic_port_op%0d: got %h expected %h", ops[i], v, exp[i]); end
    end
  endtask

  task automatic test_sync_latency();
    logic [W-1:0] v;
    int n, zeros;
    tb_val[7:0] = 8'h00;
    idle(S+2);
    tb_val[0] = 1'b1;
    n = 0;
    v = '0;
    while (n < 10 && !v[0]) begin
      cycle(1'b0, 0, 0, 8'h00);
      n++;
      rd(0, 2, v);
    end
    checks++;
    if (n !== S) begin errors++; $display("FAIL sync_latency: got %0d edges expected %0d", n, S); end
    tb_val[0] = 1'b0;
    zeros = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 0, 0, 8'h00);
      if (i == 0) tb_val[0] = 1'b1;
      rd(0, 2, v);
      if (!v[0]) zeros++;
    end
    checks++;
    if (zeros !== 1) begin errors++; $display("FAIL sync_glitch: got %0d low cycles expected 1", zeros); end
  endtask

  task automatic test_edge_flags();
    logic [W-1:0] v;
    int first;
    tb_val[1:0] = 2'b00;
    idle(S+2);
    cycle(1'b1, 0, 6, 8'h01);
    cycle(1'b1, 0, 7, 8'h02);
    tb_val[1:0] = 2'b11;
    first = -1;
    for (int n = 1; n <= 8; n++) begin
      cycle(1'b0, 0, 0, 8'h00);
      if (n == 1) tb_val[1:0] = 2'b00;
      if (bus.irq === 1'b1 && first < 0) first = n;
    end
    checks++;
    if (first !== S+1) begin errors++; $display("FAIL edge_irq_latency: got %0d expected %0d", first, S+1); end
    rd(0, 8, v);
    checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL edge_ifr: got %h expected 03", v); end
    cycle(1'b1, 0, 8, 8'h01);
    rd(0, 8, v);
    checks++;
    if (v !== 8'h02 || bus.irq !== 1'b1) begin errors++; $display("FAIL edge_w1c_bit0: got ifr %h irq %b expected 02 1", v, bus.irq); end
    cycle(1'b1, 0, 8, 8'h02);
    rd(0, 8, v);
    checks++;
    if (v !== 8'h00 || bus.irq !== 1'b0) begin errors++; $display("FAIL edge_w1c_bit1: got ifr %h irq %b expected 00 0", v, bus.irq); end
  endtask

  task automatic test_collision();
    logic [W-1:0] v;
    tb_val[0] = 1'b1;
    idle(S);
    rd(0, 8, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL coll_pre: got %h expected 00", v); end
    cycle(1'b1, 0, 8, 8'h01);
    rd(0, 8, v);
    checks++;
    if (v !== 8'h01 || v !== m_read(0, 8)) begin errors++; $display("FAIL coll_set_wins: got %h expected 01", v); end
    cycle(1'b1, 0, 8, 8'h01);
    rd(0, 8, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL coll_clear: got %h expected 00", v); end
  endtask

  task automatic test_swirq_reset();
    logic [W-1:0] v;
    int n;
    cycle(1'b1, 2, 4, 8'h80);
    idle(S+2);
    cycle(1'b1, 2, 6, 8'h80);
    cycle(1'b1, 2, 3, 8'h80);
    n = 0;
    while (n < 10 && bus.irq !== 1'b1) begin
      cycle(1'b0, 0, 0, 8'h00);
      n++;
    end
    checks++;
    if (n !== S+1) begin errors++; $display("FAIL swirq_latency: got %0d expected %0d", n, S+1); end
    rd(2, 8, v);
    checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL swirq_ifr: got %h expected 80", v); end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", bus.irq); end
    rd(2, 8, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ifr: got %h expected 00", v); end
    rd(2, 1, v);
    checks++;
    if (v !== 8'h00 || pins[23:16] !== 8'h00) begin errors++; $display("FAIL rst_port: got %h pins %h expected 00 00", v, pins[23:16]); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] v;
    int regs[5] = '{0, 1, 6, 7, 8};
    for (int r = 0; r <= 8; r++) cycle(1'b1, 3, r, 8'hFF);
    cycle(1'b1, 0, 12, 8'hFF);
    cycle(1'b1, 1, 15, 8'hFF);
    for (int r = 0; r <= 8; r++) begin
      rd(3, r, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL oor_read_r%0d: got %h expected 00", r, v); end
    end
    for (int p = 0; p < P; p++) begin
      foreach (regs[k]) begin
        rd(p, regs[k], v);
        checks++;
        if (v !== m_read(p, regs[k])) begin errors++; $display("FAIL oor_state_p%0d_r%0d: got %h expected %h", p, regs[k], v, m_read(p, regs[k])); end
      end
      for (int r = 3; r <= 15; r++) begin
        if (r == 6 || r == 7 || r == 8) continue;
        rd(p, r, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reserved_p%0d_r%0d: got %h expected 00", p, r, v); end
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL oor_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_random();
    int ps, rs;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ps = $urandom_range(0, 3);
      rs = ($urandom_range(0, 9) == 9) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      bus.wr = ($urandom_range(0, 2) == 0);
      bus.port_sel = 2'(ps);
      bus.reg_sel = 4'(rs);
      bus.dane = 8'($urandom);
      if ($urandom_range(0, 2) == 0) tb_val = tb_val ^ 24'($urandom);
      #1;
      checks++;
      if (bus.out !== m_read(ps, rs)) begin errors++; $display("FAIL rand_out_%0d p%0d r%0d: got %h expected %h", i, ps, rs, bus.out, m_read(ps, rs)); end
      checks++;
      if (bus.irq !== (|m_ifr)) begin errors++; $display("FAIL rand_irq_%0d: got %b expected %b", i, bus.irq, |m_ifr); end
      checks++;
      if (pins !== m_pad()) begin errors++; $display("FAIL rand_pins_%0d: got %h expected %h", i, pins, m_pad()); end
    end
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_atomic();
    test_sync_latency();
    test_edge_flags();
    test_collision();
    test_swirq_reset();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
